// File: rtl/pp_df_sched_pkg.sv
// Shared types and constants for the pp_pipeline_accel dataflow scheduler.
package pp_df_sched_pkg;

    localparam int PP_DF_MAX_PROC      = 16;
    localparam int PP_DF_CNT_W_DEFAULT = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/pp_df_sync_latch.sv
// Per-bit sticky latch with set enable and synchronous clear, plus an
// "all set, counting this cycle's inputs" reduction so the caller can
// react in the same cycle the last bit arrives.
module pp_df_sync_latch
    import pp_df_sched_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_en,
    input  logic [W-1:0] set_in,
    input  logic         clr,
    output logic [W-1:0] lat,
    output logic         all_set
);

    // Clear wins over set: the cycle that completes the set also closes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= '0;
        end else if (clr) begin
            lat <= '0;
        end else if (set_en) begin
            lat <= lat | set_in;
        end
    end

    // Reduction includes the live inputs so simultaneous arrivals count once.
    always_comb begin
        all_set = &(lat | set_in);
    end

endmodule

// File: rtl/pp_pipeline_accel_df_sched.sv
// Dataflow-region scheduler: fans ap_start/ap_continue out to NUM_PROC
// child processes and folds their ap_ready/ap_done into one ap_ctrl_chain
// interface. One run in flight at a time.
// Optional run-cycle counter enabled by defining PP_DF_SCHED_PERF_CNT_EN.
//
// state   | meaning
// S_IDLE  | no run; waiting for ap_start
// S_START | starting children; collecting ready (and early done)
// S_WAIT  | all children started; collecting done
// S_DONE  | run complete; ap_done held until ap_continue
module pp_pipeline_accel_df_sched
    import pp_df_sched_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int CNT_W    = PP_DF_CNT_W_DEFAULT
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic                ap_continue,
    output logic                ap_idle,
    output logic [NUM_PROC-1:0] proc_start,
    input  logic [NUM_PROC-1:0] proc_ready,
    input  logic [NUM_PROC-1:0] proc_done,
    output logic [NUM_PROC-1:0] proc_continue,
    input  logic [NUM_PROC-1:0] proc_idle
`ifdef PP_DF_SCHED_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    run_cycles,
    output logic                run_cycles_vld
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic                in_start;
    logic                in_wait;
    logic                collect;
    logic [NUM_PROC-1:0] rdy_lat;
    logic [NUM_PROC-1:0] done_lat;
    logic                all_rdy;
    logic                all_done;
    logic                rdy_clr;
    logic                done_clr;
    logic                go_done;

    // State decode and handshake qualifiers.
    always_comb begin
        in_start = (state == S_START);
        in_wait  = (state == S_WAIT);
        collect  = in_start | in_wait;
        rdy_clr  = in_start & all_rdy;
        done_clr = (state == S_DONE) & ap_continue;
        go_done  = in_wait & all_done;
    end

    pp_df_sync_latch #(.W(NUM_PROC)) u_rdy_latch (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .set_en  (in_start),
        .set_in  (proc_ready),
        .clr     (rdy_clr),
        .lat     (rdy_lat),
        .all_set (all_rdy)
    );

    // Done collection also runs in S_START: a fast child may finish before
    // the slowest sibling has accepted its start.
    pp_df_sync_latch #(.W(NUM_PROC)) u_done_latch (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .set_en  (collect),
        .set_in  (proc_done),
        .clr     (done_clr),
        .lat     (done_lat),
        .all_set (all_done)
    );

    // Next-state logic; continue together with start skips the idle bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ap_start) state_nxt = S_START;
            S_START: if (all_rdy)  state_nxt = S_WAIT;
            S_WAIT:  if (all_done) state_nxt = S_DONE;
            S_DONE:  if (ap_continue) state_nxt = ap_start ? S_START : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ap_done is registered: rises the cycle after the last child done.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ap_done <= 1'b0;
        end else if (go_done) begin
            ap_done <= 1'b1;
        end else if (done_clr) begin
            ap_done <= 1'b0;
        end
    end

    // Combinational handshake outputs toward host and children.
    always_comb begin
        ap_ready      = rdy_clr;
        ap_idle       = (state == S_IDLE) & (&proc_idle);
        proc_start    = in_start ? ~rdy_lat : '0;
        proc_continue = collect ? (proc_done & ~done_lat) : '0;
    end

`ifdef PP_DF_SCHED_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             enter_start;

    // Saturating increment; the captured value includes the final busy cycle.
    always_comb begin
        cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        enter_start = (state_nxt == S_START) & ~in_start;
    end

    // Busy-cycle counter, restarted on every run launch.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt <= '0;
        end else if (enter_start) begin
            cnt <= '0;
        end else if (collect) begin
            cnt <= cnt_inc;
        end
    end

    // Snapshot of the count on entry to S_DONE with a one-cycle valid.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            run_cycles     <= '0;
            run_cycles_vld <= 1'b0;
        end else begin
            run_cycles_vld <= go_done;
            if (go_done) begin
                run_cycles <= cnt_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_df_sched.sv
// Directed bench for the dataflow scheduler with NUM_PROC=4.
module tb_pp_pipeline_accel_df_sched;

    localparam int NP = 4;

    logic          ap_clk;
    logic          ap_rst;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_continue;
    logic          ap_idle;
    logic [NP-1:0] proc_start;
    logic [NP-1:0] proc_ready;
    logic [NP-1:0] proc_done;
    logic [NP-1:0] proc_continue;
    logic [NP-1:0] proc_idle;
`ifdef PP_DF_SCHED_PERF_CNT_EN
    logic [31:0]   run_cycles;
    logic          run_cycles_vld;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int cont_cnt [NP];
    int cont_base[NP];

    pp_pipeline_accel_df_sched #(.NUM_PROC(NP), .CNT_W(32)) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .ap_idle       (ap_idle),
        .proc_start    (proc_start),
        .proc_ready    (proc_ready),
        .proc_done     (proc_done),
        .proc_continue (proc_continue),
        .proc_idle     (proc_idle)
`ifdef PP_DF_SCHED_PERF_CNT_EN
        ,
        .run_cycles    (run_cycles),
        .run_cycles_vld(run_cycles_vld)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Count proc_continue pulses per child.
    initial for (int i = 0; i < NP; i++) cont_cnt[i] = 0;
    always @(posedge ap_clk) begin
        for (int i = 0; i < NP; i++)
            if (proc_continue[i]) cont_cnt[i] = cont_cnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic snap_cont();
        for (int i = 0; i < NP; i++) cont_base[i] = cont_cnt[i];
    endtask

    task automatic chk_cont(input string tag);
        for (int i = 0; i < NP; i++)
            chk(tag, cont_cnt[i] - cont_base[i], 1);
    endtask

    // All children done together from S_WAIT, then host acknowledges.
    task automatic end_run(input string tag);
        tick();
        proc_done = '1;
        #1;
        chk({tag, "_cont"}, proc_continue, 4'hF);
        chk({tag, "_done_lo"}, ap_done, 0);
        tick();
        proc_done = '0;
        #1;
        chk({tag, "_done_hi"}, ap_done, 1);
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        proc_idle = '1;
        #1;
        chk({tag, "_done_clr"}, ap_done, 0);
        chk({tag, "_idle"}, ap_idle, 1);
    endtask

    initial begin
        int rdy_at[NP];
        logic [NP-1:0] exp_start;
        rdy_at = '{1, 3, 5, 7};

        ap_rst = 1'b1;
        ap_start = 1'b0;
        ap_continue = 1'b0;
        proc_ready = '0;
        proc_done = '0;
        proc_idle = '1;
        #3;
        chk("rst_ready", ap_ready, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_start", proc_start, 0);
        chk("rst_cont", proc_continue, 0);
        chk("rst_idle", ap_idle, 1);
        #9 ap_rst = 1'b0;

        // Run 1: all ready at once, done after 10 cycles.
        snap_cont();
        tick();                              // cycle 0
        ap_start = 1'b1;
        proc_idle = '0;
        #1;
        chk("t1_idle_children_busy", ap_idle, 0);
        chk("t1_ready_c0", ap_ready, 0);
        tick();                              // cycle 1: S_START
        chk("t1_start", proc_start, 4'hF);
        proc_ready = '1;
        #1;
        chk("t1_ready_pulse", ap_ready, 1);
        tick();                              // cycle 2: S_WAIT
        ap_start = 1'b0;
        proc_ready = '0;
        #1;
        chk("t1_start_off", proc_start, 0);
        chk("t1_ready_off", ap_ready, 0);
        for (int c = 3; c <= 10; c++) begin
            tick();
            ap_continue = (c == 5);          // stray continue must be ignored
            #1;
            chk("t1_busy_done", ap_done, 0);
        end
        tick();                              // cycle 11
        ap_continue = 1'b0;
        proc_done = '1;
        #1;
        chk("t1_cont", proc_continue, 4'hF);
        chk("t1_done_c11", ap_done, 0);
        tick();                              // cycle 12
        proc_done = '0;
        #1;
        chk("t1_done_c12", ap_done, 1);
        chk("t1_cont_off", proc_continue, 0);
`ifdef PP_DF_SCHED_PERF_CNT_EN
        chk("t1_perf_cnt", run_cycles, 11);
        chk("t1_perf_vld", run_cycles_vld, 1);
`endif
        tick();                              // cycle 13
`ifdef PP_DF_SCHED_PERF_CNT_EN
        chk("t1_perf_vld_off", run_cycles_vld, 0);
`endif
        chk("t1_done_hold13", ap_done, 1);
        tick();                              // cycle 14
        chk("t1_done_hold14", ap_done, 1);
        ap_continue = 1'b1;
        tick();                              // cycle 15
        ap_continue = 1'b0;
        proc_idle = '1;
        #1;
        chk("t1_done_clr", ap_done, 0);
        chk("t1_idle_back", ap_idle, 1);
        chk_cont("t1_cont_once");

        // Run 2: staggered ready at +1,+3,+5,+7.
        snap_cont();
        tick();
        ap_start = 1'b1;
        proc_idle = '0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            for (int i = 0; i < NP; i++) begin
                exp_start[i] = (rdy_at[i] >= c);
                proc_ready[i] = (rdy_at[i] == c);
            end
            chk("t2_start", proc_start, exp_start);
            #1;
            chk("t2_ready", ap_ready, (c == 7));
            if (c == 7) ap_start = 1'b0;
        end
        tick();
        proc_ready = '0;
        #1;
        chk("t2_start_off", proc_start, 0);
        chk("t2_ready_off", ap_ready, 0);
        end_run("t2");
        chk_cont("t2_cont_once");

        // Run 3: child 2 finishes before child 3 is ready.
        snap_cont();
        tick();
        ap_start = 1'b1;
        proc_idle = '0;
        tick();                              // cycle 1
        proc_ready = 4'b0111;
        #1;
        chk("t3_ready_c1", ap_ready, 0);
        tick();                              // cycle 2
        proc_ready = '0;
        proc_done = 4'b0100;
        #1;
        chk("t3_start_c2", proc_start, 4'b1000);
        chk("t3_cont_early", proc_continue, 4'b0100);
        tick();                              // cycle 3: done[2] still high
        #1;
        chk("t3_cont_once", proc_continue, 0);
        tick();                              // cycle 4
        proc_done = '0;
        proc_ready = 4'b1000;
        #1;
        chk("t3_ready_c4", ap_ready, 1);
        ap_start = 1'b0;
        tick();                              // cycle 5
        proc_ready = '0;
        #1;
        chk("t3_done_c5", ap_done, 0);
        tick();                              // cycle 6
        proc_done = 4'b1011;
        #1;
        chk("t3_cont_rest", proc_continue, 4'b1011);
        tick();                              // cycle 7
        proc_done = '0;
        #1;
        chk("t3_done_c7", ap_done, 1);
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        proc_idle = '1;
        #1;
        chk("t3_done_clr", ap_done, 0);
        chk_cont("t3_cont_once_each");

        // Run 4: back-to-back through continue+start.
        tick();
        ap_start = 1'b1;
        proc_idle = '0;
        tick();
        proc_ready = '1;
        #1;
        chk("t4_ready_a", ap_ready, 1);
        ap_start = 1'b0;
        tick();
        proc_ready = '0;
        tick();
        proc_done = '1;
        tick();
        proc_done = '0;
        proc_idle = '1;
        #1;
        chk("t4_done_a", ap_done, 1);
        ap_continue = 1'b1;
        ap_start = 1'b1;
        snap_cont();
        tick();
        ap_continue = 1'b0;
        proc_idle = '0;
        #1;
        chk("t4_restart", proc_start, 4'hF);
        chk("t4_done_drop", ap_done, 0);
        chk("t4_no_idle", ap_idle, 0);
        proc_ready = '1;
        #1;
        chk("t4_ready_b", ap_ready, 1);
        ap_start = 1'b0;
        tick();
        proc_ready = '0;
        #1;
        chk("t4_start_off_b", proc_start, 0);
        end_run("t4");
        chk_cont("t4_cont_once");

        // Run 5: asynchronous reset in S_WAIT, then a clean run.
        tick();
        ap_start = 1'b1;
        proc_idle = '0;
        tick();
        proc_ready = '1;
        #1;
        ap_start = 1'b0;
        tick();
        proc_ready = '0;
        proc_done = 4'b0001;
        #1;
        chk("t5_cont_pre0", proc_continue, 4'b0001);
        tick();
        proc_done = 4'b0010;
        #1;
        chk("t5_cont_pre1", proc_continue, 4'b0010);
        #2 ap_rst = 1'b1;
        #1;
        chk("t5_rst_cont", proc_continue, 0);
        chk("t5_rst_done", ap_done, 0);
        chk("t5_rst_start", proc_start, 0);
        proc_done = '0;
        proc_idle = '1;
        #1;
        chk("t5_rst_idle", ap_idle, 1);
        #2 ap_rst = 1'b0;
        snap_cont();
        tick();
        ap_start = 1'b1;
        proc_idle = '0;
        tick();
        chk("t5_start", proc_start, 4'hF);
        proc_ready = '1;
        #1;
        chk("t5_ready", ap_ready, 1);
        ap_start = 1'b0;
        tick();
        proc_ready = '0;
        proc_done = 4'b0001;
        #1;
        chk("t5_cont0", proc_continue, 4'b0001);
        tick();
        proc_done = 4'b1110;
        #1;
        chk("t5_cont_rest", proc_continue, 4'b1110);
        chk("t5_done_lo", ap_done, 0);
        tick();
        proc_done = '0;
        #1;
        chk("t5_done_hi", ap_done, 1);
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        #1;
        chk("t5_done_clr", ap_done, 0);
        chk_cont("t5_cont_once");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
